// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared access-size encodings, FSM states and alignment rule.
package load_store_unit_pkg;
   typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_DOUBLE = 2'b11} size_t;
   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
   function automatic logic misaligned(size_t sz, logic [2:0] a);
      return (sz == SZ_HALF) ? a[0] : (sz == SZ_WORD) ? |a[1:0] : (sz == SZ_DOUBLE) ? |a : 1'b0;
   endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response memory bus between the LSU and data memory.
interface load_store_unit_if #(parameter int WORD_SIZE = 32, parameter int ADDR_SIZE = 10);
   logic                   mem_req_valid, mem_req_ready, mem_req_we;
   logic [ADDR_SIZE-1:0]   mem_req_addr;
   logic [WORD_SIZE-1:0]   mem_req_wdata;
   logic [WORD_SIZE/8-1:0] mem_req_be;
   logic                   mem_resp_valid;
   logic [WORD_SIZE-1:0]   mem_resp_rdata;
   modport master(output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be,
                  input mem_req_ready, mem_resp_valid, mem_resp_rdata);
   modport slave(input mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be,
                 output mem_req_ready, mem_resp_valid, mem_resp_rdata);
endinterface

// File: rtl/load_store_unit_load_align.sv
// load_align: picks the addressed lane out of a read word and sign/zero-extends it.
module load_align import load_store_unit_pkg::*; #(
   parameter int WORD_SIZE = 32,
   parameter int LB = $clog2(WORD_SIZE/8)
) (
   input  logic [WORD_SIZE-1:0] rdata,
   input  logic [LB-1:0]        lane,
   input  size_t                size,
   input  logic                 sign,
   output logic [WORD_SIZE-1:0] data
);
   localparam int SW = $clog2(WORD_SIZE);
   logic [WORD_SIZE-1:0]        s, up;
   logic signed [WORD_SIZE-1:0] sx;
   logic [SW-1:0]               sh;
   // Left-justify the field, then shift back arithmetically or logically to extend it.
   always_comb begin
      s = rdata >> {lane, 3'b000};
      sh = (size == SZ_BYTE) ? SW'(WORD_SIZE - 8) : (size == SZ_HALF) ? SW'(WORD_SIZE - 16) :
           (size == SZ_WORD) ? SW'(WORD_SIZE - 32) : '0;
      up = s << sh;
      sx = $signed(up) >>> sh;
      data = sign ? up >> sh : sx;
   end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM stage -- issues aligned memory requests, stalls the pipe until
// the access completes, registers MEM/WB, and resolves branches/jumps.
module load_store_unit import load_store_unit_pkg::*; #(
   parameter int WORD_SIZE = 32,
   parameter int NUM_REGS = 32,
   parameter int REG_SEL = $clog2(NUM_REGS),
   parameter int ADDR_SIZE = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [WORD_SIZE-1:0] result,
   input  logic [WORD_SIZE-1:0] save_data,
   input  logic [REG_SEL-1:0]   rd,
   input  logic                 reg_write,
   input  logic                 mem_read,
   input  logic                 mem_write,
   input  logic                 branch,
   input  logic                 jump,
   input  logic                 zero,
   input  logic                 data_sign,
   input  logic [1:0]           data_size,
   load_store_unit_if.master    bus,
   output logic                 stall,
   output logic                 wb_valid,
   output logic [WORD_SIZE-1:0] wb_data,
   output logic [REG_SEL-1:0]   wb_rd,
   output logic                 wb_reg_write,
   output logic                 misalign,
   output logic                 pc_src,
   output logic                 flush_ifid,
   output logic                 flush_idex,
   output logic                 flush_exmem
);
   localparam int LB = $clog2(WORD_SIZE/8);
   localparam int BW = WORD_SIZE/8;
   state_t               state_q, state_d;
   size_t                size, r_size;
   logic                 mem_op, mis, hs, done, stall_c, alu_op;
   logic                 r_sign, r_we, r_rw;
   logic [LB-1:0]        lane, r_lane;
   logic [REG_SEL-1:0]   r_rd;
   logic [ADDR_SIZE-1:0] r_addr;
   logic [WORD_SIZE-1:0] r_wdata, ld_data;
   logic [BW-1:0]        be, r_be;
   assign size = size_t'(data_size);
   assign lane = result[LB-1:0];
   assign mem_op = in_valid & (mem_read | mem_write);
   assign alu_op = state_q == IDLE && in_valid && !mem_op;
   assign mis = misaligned(size, result[2:0]);
   assign hs = bus.mem_req_valid & bus.mem_req_ready;
   assign be = ((size == SZ_BYTE) ? BW'(1) : (size == SZ_HALF) ? BW'(3) : (size == SZ_WORD) ? BW'(15) : '1) << lane;
   always_comb begin
      state_d = state_q;
      stall_c = 1'b0;
      done = 1'b0;
      case (state_q)
         IDLE: begin
            stall_c = mem_op & ~mis;
            state_d = stall_c ? REQ : IDLE;
         end
         REQ: begin
            done = hs & (r_we | bus.mem_resp_valid);
            stall_c = ~done;
            state_d = done ? IDLE : hs ? RESP : REQ;
         end
         RESP: begin
            done = bus.mem_resp_valid;
            stall_c = ~done;
            state_d = done ? IDLE : RESP;
         end
         default: state_d = IDLE;
      endcase
   end
   // Combinational outputs are gated so reset forces them low immediately.
   assign stall = rst & stall_c;
   assign pc_src = rst & in_valid & (jump | (branch & zero));
   assign flush_ifid = pc_src;
   assign flush_idex = pc_src;
   assign flush_exmem = pc_src;
   assign bus.mem_req_valid = state_q == REQ;
   assign bus.mem_req_we = r_we;
   assign bus.mem_req_addr = r_addr;
   assign bus.mem_req_wdata = r_wdata;
   assign bus.mem_req_be = r_be;
   load_align #(.WORD_SIZE(WORD_SIZE)) u_align (
      .rdata(bus.mem_resp_rdata), .lane(r_lane), .size(r_size), .sign(r_sign), .data(ld_data)
   );
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         r_size <= SZ_BYTE;
         {r_sign, r_we, r_rw, r_lane, r_rd, r_addr, r_wdata, r_be} <= '0;
         {wb_valid, wb_data, wb_rd, wb_reg_write, misalign} <= '0;
      end else begin
         state_q <= state_d;
         misalign <= state_q == IDLE && mem_op && mis;
         wb_valid <= done || alu_op;
         if (state_q == IDLE && state_d == REQ) begin
            r_addr <= {result[ADDR_SIZE-1:LB], LB'(0)};
            r_wdata <= save_data << {lane, 3'b000};
            r_be <= be;
            r_we <= mem_write;
            r_rd <= rd;
            r_rw <= reg_write;
            r_size <= size;
            r_sign <= data_sign;
            r_lane <= lane;
         end
         if (done) begin
            wb_data <= ld_data;
            wb_rd <= r_rd;
            wb_reg_write <= r_rw & ~r_we;
         end else if (alu_op) begin
            wb_data <= result;
            wb_rd <= rd;
            wb_reg_write <= reg_write;
         end else
            wb_reg_write <= 1'b0;
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scenarios with a writeback scoreboard for load_store_unit.
module tb_load_store_unit;
   import load_store_unit_pkg::*;
   logic clk = 0, rst = 0;
   always #5 clk = ~clk;
   logic in_valid, reg_write, mem_read, mem_write, branch, jump, zero, data_sign;
   logic [31:0] result, save_data, wb_data;
   logic [4:0] rd, wb_rd;
   logic [1:0] data_size;
   logic stall, wb_valid, wb_reg_write, misalign, pc_src, flush_ifid, flush_idex, flush_exmem;
   typedef struct {logic [31:0] data; logic [4:0] rd; logic rw;} exp_t;
   typedef struct {logic [9:0] addr; logic [31:0] wdata; logic [3:0] be; logic we; bit stable; int stalls;} req_t;
   exp_t exp_q[$];
   int errors = 0, checks = 0;

   load_store_unit_if #(.WORD_SIZE(32), .ADDR_SIZE(10)) bus ();
   load_store_unit #(.WORD_SIZE(32), .NUM_REGS(32), .ADDR_SIZE(10)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .result(result), .save_data(save_data), .rd(rd),
      .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .jump(jump),
      .zero(zero), .data_sign(data_sign), .data_size(data_size), .bus(bus), .stall(stall),
      .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
      .misalign(misalign), .pc_src(pc_src), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
      .flush_exmem(flush_exmem)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear;
      {in_valid, reg_write, mem_read, mem_write, branch, jump, zero, data_sign} = '0;
      {result, save_data, rd, data_size} = '0;
      {bus.mem_req_ready, bus.mem_resp_valid, bus.mem_resp_rdata} = '0;
   endtask

   // Drives one memory op and acts as the memory: ready after rdy_wait REQ cycles,
   // response resp_wait cycles after the handshake (0 = same cycle).
   task automatic access(input logic [31:0] addr, sdata, rdata, input logic [1:0] sz,
                         input logic sgn, we, rw, input logic [4:0] dst,
                         input int rdy_wait, resp_wait, output req_t r);
      int req_cyc = 0, hs_c = -1;
      bit seen = 0, fin = 0;
      r = '{default: 0};
      r.stable = 1;
      in_valid = 1; result = addr; save_data = sdata; data_size = sz; data_sign = sgn;
      mem_read = !we; mem_write = we; rd = dst; reg_write = rw; bus.mem_resp_rdata = rdata;
      for (int c = 0; c < 40 && !fin; c++) begin
         bus.mem_req_ready = bus.mem_req_valid && req_cyc >= rdy_wait;
         if (bus.mem_req_ready) hs_c = c;
         bus.mem_resp_valid = !we && hs_c >= 0 && c == hs_c + resp_wait;
         @(negedge clk);
         if (bus.mem_req_valid) begin
            if (!seen) {r.addr, r.wdata, r.be, r.we} = {bus.mem_req_addr, bus.mem_req_wdata, bus.mem_req_be, bus.mem_req_we};
            else if ({bus.mem_req_addr, bus.mem_req_wdata, bus.mem_req_be, bus.mem_req_we} !== {r.addr, r.wdata, r.be, r.we}) r.stable = 0;
            seen = 1;
            req_cyc++;
         end
         if (stall === 1'b1) r.stalls++;
         else fin = 1;
         tick;
      end
      clear;
   endtask

   task automatic next_wb(output bit seen, output exp_t e);
      seen = 0;
      e = '{default: 0};
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge clk);
         seen = wb_valid === 1'b1;
      end
      if (exp_q.size() > 0) e = exp_q.pop_front();
   endtask

   task automatic test_reset;
      in_valid = 1; mem_read = 1; jump = 1; result = 32'h3; rd = 5; reg_write = 1; rst = 0;
      repeat (2) @(negedge clk);
      checks++; if ({stall, pc_src, flush_ifid, flush_idex, flush_exmem, wb_valid, wb_reg_write, misalign, bus.mem_req_valid, bus.mem_req_we} !== '0) begin
         errors++; $display("FAIL reset_ctrl got %b want 0", {stall, pc_src, flush_ifid, flush_idex, flush_exmem, wb_valid, wb_reg_write, misalign, bus.mem_req_valid, bus.mem_req_we}); end
      checks++; if ({wb_data, wb_rd, bus.mem_req_addr, bus.mem_req_wdata, bus.mem_req_be} !== '0) begin
         errors++; $display("FAIL reset_data got %h want 0", {wb_data, wb_rd, bus.mem_req_addr, bus.mem_req_wdata, bus.mem_req_be}); end
      clear;
      tick;
      rst = 1;
   endtask

   task automatic test_load_byte;
      req_t r; exp_t e; bit s;
      tick;
      exp_q.push_back('{32'hFFFF_FF80, 5'd5, 1'b1});
      access(32'h003, 32'h0, 32'h80FF_FF12, 2'b00, 1'b0, 1'b0, 1'b1, 5'd5, 0, 2, r);
      checks++; if (r.addr !== 10'h000) begin errors++; $display("FAIL lb_addr got %h want 000", r.addr); end
      checks++; if (r.we !== 1'b0) begin errors++; $display("FAIL lb_we got %b want 0", r.we); end
      checks++; if (r.stalls != 3) begin errors++; $display("FAIL lb_stall_cycles got %0d want 3", r.stalls); end
      next_wb(s, e);
      checks++; if (!s) begin errors++; $display("FAIL lb_wb_valid got 0 want 1"); end
      checks++; if (wb_data !== e.data) begin errors++; $display("FAIL lb_wb_data got %h want %h", wb_data, e.data); end
      checks++; if ({wb_rd, wb_reg_write} !== {e.rd, e.rw}) begin errors++; $display("FAIL lb_wb_rd got %0d/%b want %0d/%b", wb_rd, wb_reg_write, e.rd, e.rw); end
   endtask

   task automatic test_load_half_unsigned;
      req_t r; exp_t e; bit s;
      tick;
      exp_q.push_back('{32'h0000_8001, 5'd7, 1'b1});
      access(32'h002, 32'h0, 32'h8001_0000, 2'b01, 1'b1, 1'b0, 1'b1, 5'd7, 0, 1, r);
      checks++; if (r.addr !== 10'h000) begin errors++; $display("FAIL lhu_addr got %h want 000", r.addr); end
      next_wb(s, e);
      checks++; if (!s || wb_data !== e.data || wb_rd !== e.rd) begin errors++; $display("FAIL lhu_wb got v=%b %h rd=%0d want %h rd=%0d", s, wb_data, wb_rd, e.data, e.rd); end
   endtask

   task automatic test_same_cycle_resp;
      req_t r; exp_t e; bit s;
      tick;
      exp_q.push_back('{32'hFFFF_F00D, 5'd12, 1'b1});
      access(32'h004, 32'h0, 32'h1234_F00D, 2'b01, 1'b0, 1'b0, 1'b1, 5'd12, 0, 0, r);
      checks++; if (r.addr !== 10'h004) begin errors++; $display("FAIL lh_same_addr got %h want 004", r.addr); end
      checks++; if (r.stalls != 1) begin errors++; $display("FAIL lh_same_stalls got %0d want 1", r.stalls); end
      next_wb(s, e);
      checks++; if (!s || wb_data !== e.data) begin errors++; $display("FAIL lh_same_wb got v=%b %h want %h", s, wb_data, e.data); end
   endtask

   task automatic test_store;
      req_t r; exp_t e; bit s;
      logic [31:0] sa[2] = '{32'h001, 32'h002};
      logic [31:0] sd[2] = '{32'h0000_00AB, 32'h0000_1234};
      logic [31:0] wd[2] = '{32'h0000_AB00, 32'h1234_0000};
      logic [3:0]  wb[2] = '{4'b0010, 4'b1100};
      logic [1:0]  sz[2] = '{2'b00, 2'b01};
      for (int i = 0; i < 2; i++) begin
         tick;
         exp_q.push_back('{32'h0, 5'd3, 1'b0});
         access(sa[i], sd[i], 32'h0, sz[i], 1'b0, 1'b1, 1'b1, 5'd3, 0, 0, r);
         checks++; if ({r.be, r.wdata, r.we, r.addr} !== {wb[i], wd[i], 1'b1, 10'h000}) begin
            errors++; $display("FAIL store%0d_req got be=%b wd=%h we=%b a=%h want be=%b wd=%h we=1 a=000", i, r.be, r.wdata, r.we, r.addr, wb[i], wd[i]); end
         checks++; if (r.stalls != 1) begin errors++; $display("FAIL store%0d_stalls got %0d want 1", i, r.stalls); end
         next_wb(s, e);
         checks++; if (!s || wb_reg_write !== e.rw) begin errors++; $display("FAIL store%0d_wb got v=%b rw=%b want v=1 rw=%b", i, s, wb_reg_write, e.rw); end
      end
   endtask

   task automatic test_misaligned;
      tick;
      in_valid = 1; mem_read = 1; result = 32'h002; data_size = 2'b10; rd = 6; reg_write = 1;
      @(negedge clk);
      checks++; if ({stall, bus.mem_req_valid} !== 2'b00) begin errors++; $display("FAIL mis_no_req got stall/valid=%b want 00", {stall, bus.mem_req_valid}); end
      tick;
      clear;
      @(negedge clk);
      checks++; if ({misalign, wb_reg_write, bus.mem_req_valid} !== 3'b100) begin errors++; $display("FAIL mis_pulse got %b want 100", {misalign, wb_reg_write, bus.mem_req_valid}); end
      tick;
      @(negedge clk);
      checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_one_cycle got %b want 0", misalign); end
   endtask

   task automatic test_backpressure;
      req_t r; exp_t e; bit s;
      tick;
      exp_q.push_back('{32'hCAFE_F00D, 5'd9, 1'b1});
      access(32'h008, 32'h0, 32'hCAFE_F00D, 2'b10, 1'b0, 1'b0, 1'b1, 5'd9, 5, 1, r);
      checks++; if (r.stable !== 1'b1) begin errors++; $display("FAIL bp_stable got %b want 1", r.stable); end
      checks++; if (r.addr !== 10'h008) begin errors++; $display("FAIL bp_addr got %h want 008", r.addr); end
      checks++; if (r.stalls != 7) begin errors++; $display("FAIL bp_stalls got %0d want 7", r.stalls); end
      next_wb(s, e);
      checks++; if (!s || wb_data !== e.data || wb_rd !== e.rd) begin errors++; $display("FAIL bp_wb got v=%b %h rd=%0d want %h rd=%0d", s, wb_data, wb_rd, e.data, e.rd); end
   endtask

   task automatic test_back_to_back;
      exp_t e;
      logic [31:0] rv[3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
      logic [2:0]  bjz[3] = '{3'b101, 3'b100, 3'b010};
      logic        pc;
      tick;
      for (int c = 0; c < 4; c++) begin
         if (c < 3) begin
            in_valid = 1; result = rv[c]; rd = 5'(c + 1); reg_write = c != 1;
            {branch, jump, zero} = bjz[c];
            pc = bjz[c][1] | (bjz[c][2] & bjz[c][0]);
            exp_q.push_back('{rv[c], 5'(c + 1), c != 1});
         end else clear;
         @(negedge clk);
         if (c < 3) begin
            checks++; if ({pc_src, flush_ifid, flush_idex, flush_exmem, stall} !== {{4{pc}}, 1'b0}) begin
               errors++; $display("FAIL b2b%0d_pc got %b want %b", c, {pc_src, flush_ifid, flush_idex, flush_exmem, stall}, {{4{pc}}, 1'b0}); end
         end
         if (c > 0) begin
            e = exp_q.size() > 0 ? exp_q.pop_front() : '{32'h0, 5'd0, 1'b0};
            checks++; if ({wb_valid, wb_data, wb_rd, wb_reg_write} !== {1'b1, e.data, e.rd, e.rw}) begin
               errors++; $display("FAIL b2b%0d_wb got v=%b %h rd=%0d rw=%b want %h rd=%0d rw=%b", c, wb_valid, wb_data, wb_rd, wb_reg_write, e.data, e.rd, e.rw); end
         end
         tick;
      end
      @(negedge clk);
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", wb_valid); end
   endtask

   task automatic test_reset_in_resp;
      req_t r; exp_t e; bit s;
      tick;
      in_valid = 1; mem_read = 1; result = 32'h0; rd = 4; reg_write = 1; bus.mem_req_ready = 1;
      tick;
      tick;
      bus.mem_req_ready = 0;
      @(negedge clk);
      checks++; if ({stall, bus.mem_req_valid} !== 2'b10) begin errors++; $display("FAIL rr_in_resp got %b want 10", {stall, bus.mem_req_valid}); end
      #1 rst = 0;
      #1;
      checks++; if ({stall, wb_valid, wb_reg_write, misalign, pc_src, bus.mem_req_valid, wb_data} !== '0) begin
         errors++; $display("FAIL rr_async got %b/%h want 0", {stall, wb_valid, wb_reg_write, misalign, pc_src, bus.mem_req_valid}, wb_data); end
      @(posedge clk);
      #1 rst = 1;
      clear;
      bus.mem_resp_valid = 1; bus.mem_resp_rdata = 32'h0000_00FF;
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rr_idle_stall got %b want 0", stall); end
      tick;
      clear;
      @(negedge clk);
      checks++; if ({wb_valid, bus.mem_req_valid} !== 2'b00) begin errors++; $display("FAIL rr_stale_resp got %b want 00", {wb_valid, bus.mem_req_valid}); end
      tick;
      exp_q.push_back('{32'h0000_00AB, 5'd8, 1'b1});
      access(32'h002, 32'h0, 32'h00AB_0000, 2'b00, 1'b1, 1'b0, 1'b1, 5'd8, 0, 1, r);
      next_wb(s, e);
      checks++; if (!s || wb_data !== e.data) begin errors++; $display("FAIL rr_after_lbu got v=%b %h want %h", s, wb_data, e.data); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      clear;
      test_reset;
      test_load_byte;
      test_load_half_unsigned;
      test_same_cycle_resp;
      test_store;
      test_misaligned;
      test_backpressure;
      test_back_to_back;
      test_reset_in_resp;
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, datapath width; legal values are 32 and 64.
REQ-002 SHALL have parameter NUM_REGS, default 32, register-file depth.
REQ-003 SHALL have parameter REG_SEL, default $clog2(NUM_REGS), destination-register select width.
REQ-004 SHALL have parameter ADDR_SIZE, default 10, byte-address width driven to memory.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst input 1, asynchronous active-low reset.
REQ-006 SHALL have the following stage-input ports:
- in_valid input 1: EX/MEM holds an instruction.
- result input WORD_SIZE: ALU result / effective address.
- save_data input WORD_SIZE: store data (rs2).
- rd input REG_SEL: destination register.
- reg_write input 1: instruction writes rd.
- mem_read input 1: load; mem_write input 1: store.
- branch input 1, jump input 1, zero input 1: control-flow resolution.
- data_sign input 1: 0 signed, 1 unsigned.
- data_size input 2: 00 byte, 01 half, 10 word, 11 double (WORD_SIZE=64 only).
REQ-007 SHALL have the following memory-side ports:
- mem_req_valid output 1, mem_req_ready input 1: request handshake.
- mem_req_we output 1: request is a write.
- mem_req_addr output ADDR_SIZE: word-aligned byte address.
- mem_req_wdata output WORD_SIZE: lane-shifted store data.
- mem_req_be output WORD_SIZE/8: byte enables.
- mem_resp_valid input 1, mem_resp_rdata input WORD_SIZE: read response.
REQ-008 SHALL have the following outputs:
- stall output 1: freeze IF..EX.
- wb_valid output 1, wb_data output WORD_SIZE, wb_rd output REG_SEL, wb_reg_write output 1: MEM/WB register.
- misalign output 1: one-cycle fault pulse.
- pc_src output 1: take branch/jump target.
- flush_ifid output 1, flush_idex output 1, flush_exmem output 1: pipeline flushes.

Function
REQ-009 SHALL implement FSM states IDLE, REQ, RESP; IDLE->REQ when in_valid & (mem_read|mem_write) & aligned; REQ->RESP on mem_req_valid&mem_req_ready for loads; REQ->IDLE on handshake for stores; RESP->IDLE on mem_resp_valid.
REQ-010 SHALL hold mem_req_valid and all request fields stable in REQ until mem_req_ready is sampled high.
REQ-011 SHALL assert stall combinationally whenever a memory op is in IDLE-accepting or the FSM is in REQ/RESP, and deassert it in the cycle the access completes.
REQ-012 SHALL compute byte lane = result[log2(WORD_SIZE/8)-1:0], shift save_data and be left by lane*8, and drive mem_req_addr with lane bits zeroed.
REQ-013 SHALL treat half on odd address, word on non-multiple-of-4, or double on non-multiple-of-8 as misaligned: no request issued, misalign pulses one cycle, wb_reg_write=0.
REQ-014 SHALL extract the load lane from mem_resp_rdata and sign-extend (data_sign=0) or zero-extend (data_sign=1) to WORD_SIZE.
REQ-015 SHALL register wb_data/wb_rd/wb_reg_write/wb_valid one cycle after access completion for memory ops, and one cycle after in_valid for non-memory ops (wb_data=result).
REQ-016 SHALL drive pc_src = in_valid & (jump | (branch & zero)) combinationally, and assert flush_ifid, flush_idex, flush_exmem in that same cycle.
REQ-017 SHALL ignore mem_resp_valid outside RESP.
REQ-018 SHALL, when mem_req_ready and mem_resp_valid arrive in the same cycle, complete the load directly from REQ to IDLE.

Reset
REQ-019 SHALL on rst low immediately force FSM=IDLE and all outputs to 0, abandoning any in-flight request with no retry.

Structure
REQ-020 SHALL take the data_size encodings and FSM state typedef from the shared core package.
REQ-021 SHALL place lane extraction/extension in one sub-module, load_align.

Verification
REQ-022 SHALL pass the following directed scenarios:
- LB at addr 0x003, rdata=0x80FF_FF12 (mem_req_ready=1, response 2 cycles later) -> wb_data=0xFFFF_FF80, stall high 3 cycles.
- LHU at 0x002, rdata=0x8001_0000 -> wb_data=0x0000_8001.
- SB at 0x001, save_data=0xAB -> be=0010, wdata=0x0000_AB00, wb_reg_write=0.
- LW at 0x002 -> no request, misalign pulse, wb_reg_write=0.
- mem_req_ready low 5 cycles -> request fields stable, stall held.
- rst low during RESP -> outputs 0, FSM IDLE.
